// File: rtl/ssb_mod_pkg.sv
// Shared definitions for the SSB modulator: FSM states, default widths,
// the Hilbert coefficient table and the rounding constant.
package ssb_mod_pkg;

    localparam int TAPS_DEF   = 31;
    localparam int DW_DEF     = 12;
    localparam int CW_DEF     = 16;
    // Adding half an LSB of the Q1.15 product gives round-half-up.
    localparam int ROUND_BIAS = 1 << 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } ssb_state_e;

    // Hilbert tap magnitude at odd offset m from the centre, Q1.15.
    // Ideal value 2/(pi*m), shaped by a Blackman window over the half-span
    // (C+1 = 16) and normalised so h_1 keeps the ideal 2/pi = 20861.
    // The tap at C+m is the negation of the tap at C-m.
    function automatic logic signed [CW_DEF-1:0] h_m(input int m);
        logic signed [CW_DEF-1:0] h;
        case (m)
            1:       h = 16'sd20861;
            3:       h = 16'sd6120;
            5:       h = 16'sd2828;
            7:       h = 16'sd1343;
            9:       h = 16'sd585;
            11:      h = 16'sd215;
            13:      h = 16'sd57;
            15:      h = 16'sd5;
            default: h = 16'sd0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/ssb_modulator_mac.sv
// Hilbert MAC core: audio delay line, coefficient selection and the
// accumulator.  One antisymmetric tap pair is folded in per enabled cycle.
module hilbert_mac_core
    import ssb_mod_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int SW   = 3,
    parameter int AW   = DW + CW + 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift_i,
    input  logic signed [DW-1:0] sample_i,
    input  logic                 clear_i,
    input  logic                 mac_en_i,
    input  logic [SW-1:0]        step_i,
    output logic signed [AW-1:0] acc_o,
    output logic signed [DW-1:0] centre_o
);

    localparam int C  = (TAPS - 1) / 2;
    localparam int IW = $clog2(TAPS);
    localparam int PW = DW + 1 + CW;

    logic signed [DW-1:0] x_q [TAPS];
    logic signed [DW-1:0] x_d [TAPS];
    logic signed [AW-1:0] acc_q, acc_d;

    int                   m_int;
    logic [IW-1:0]        idx_new, idx_old;
    logic signed [CW-1:0] coef;
    logic signed [DW:0]   diff;
    logic signed [PW-1:0] prod;

    // Tap-pair selection and product for the current step (m = 2*step+1).
    always_comb begin
        m_int   = 2 * int'(step_i) + 1;
        idx_new = IW'(C - m_int);
        idx_old = IW'(C + m_int);
        coef    = CW'(h_m(m_int));
        diff    = (DW + 1)'(x_q[idx_new]) - (DW + 1)'(x_q[idx_old]);
        prod    = PW'(diff) * PW'(coef);
    end

    // Next delay line (shift on acceptance) and next accumulator value.
    always_comb begin
        x_d = x_q;
        if (shift_i) begin
            x_d[0] = sample_i;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
        end
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (mac_en_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    // Delay line and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            x_q   <= x_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o    = acc_q;
    assign centre_o = x_q[C];

endmodule

// File: rtl/ssb_modulator.sv
// SSB modulator top: accepts a 12-bit audio strobe, runs the sequential
// Hilbert FIR, and presents I (delayed audio) and Q (Hilbert, sign set by
// sideband) with a one-cycle out_valid.
// Build option: define SSB_MOD_SATURATE_EN to saturate Q and -Q to the
// output range; otherwise they wrap to DW bits.
// Handshake: in_valid is a one-cycle strobe accepted only in IDLE; a strobe
// in any other state is dropped and flagged on overrun the next cycle.
// out_valid is a one-cycle strobe with no back-pressure.
module ssb_modulator
    import ssb_mod_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] audio_in,
    input  logic                 in_valid,
    input  logic                 add_sub,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun,
    output logic [1:0]           dbg_state
);

    localparam int C  = (TAPS - 1) / 2;
    localparam int P  = (C + 1) / 2;
    localparam int SW = (P > 1) ? $clog2(P) : 1;
    localparam int AW = DW + CW + 6;
    localparam int QW = AW - 15;

    ssb_state_e           state_q, state_d;
    logic [SW-1:0]        step_q, step_d;
    logic                 sb_q, sb_d;
    logic signed [DW-1:0] i_q, i_d;
    logic signed [DW-1:0] q_q, q_d;
    logic                 ovr_q, ovr_d;

    logic                 accept;
    logic                 mac_en;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] centre;
    logic signed [AW-1:0] acc_rnd;
    logic signed [QW-1:0] q_full;
    logic signed [QW:0]   q_sel;
    logic signed [DW-1:0] q_red;

`ifdef SSB_MOD_SATURATE_EN
    localparam logic signed [QW:0] Q_MAX = (QW + 1)'((1 << (DW - 1)) - 1);
    localparam logic signed [QW:0] Q_MIN = (QW + 1)'(-(1 << (DW - 1)));
`endif

    hilbert_mac_core #(
        .TAPS(TAPS),
        .DW  (DW),
        .CW  (CW),
        .SW  (SW),
        .AW  (AW)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (accept),
        .sample_i(audio_in),
        .clear_i (accept),
        .mac_en_i(mac_en),
        .step_i  (step_q),
        .acc_o   (acc),
        .centre_o(centre)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (step_q == SW'(P - 1)) state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and control strobes decoded from the current state.
    always_comb begin
        accept    = (state_q == IDLE) && in_valid;
        mac_en    = (state_q == MAC);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        dbg_state = state_q;
    end

    // Round, apply sideband and reduce Q to the output width.
    always_comb begin
        acc_rnd = acc + AW'(ROUND_BIAS);
        q_full  = QW'(acc_rnd >>> 15);
        q_sel   = sb_q ? (QW + 1)'(q_full) : -((QW + 1)'(q_full));
`ifdef SSB_MOD_SATURATE_EN
        if (q_sel > Q_MAX) begin
            q_red = DW'(Q_MAX);
        end else if (q_sel < Q_MIN) begin
            q_red = DW'(Q_MIN);
        end else begin
            q_red = DW'(q_sel);
        end
`else
        q_red = DW'(q_sel);
`endif
    end

    // Next values for the step counter, sideband latch, outputs and overrun.
    always_comb begin
        step_d = step_q;
        sb_d   = sb_q;
        i_d    = i_q;
        q_d    = q_q;
        ovr_d  = in_valid && (state_q != IDLE);
        if (accept) begin
            step_d = '0;
            sb_d   = add_sub;
        end else if (state_q == MAC) begin
            step_d = step_q + SW'(1);
        end
        if (state_q == ROUND) begin
            i_d = centre;
            q_d = q_red;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            sb_q   <= 1'b0;
            i_q    <= '0;
            q_q    <= '0;
            ovr_q  <= 1'b0;
        end else begin
            step_q <= step_d;
            sb_q   <= sb_d;
            i_q    <= i_d;
            q_q    <= q_d;
            ovr_q  <= ovr_d;
        end
    end

    assign i_out   = i_q;
    assign q_out   = q_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_ssb_modulator.sv
// Self-checking bench for ssb_modulator: directed stimulus, expected I/Q
// pushed on each accepted sample, popped and compared on out_valid.
`timescale 1ns/1ps
module tb_ssb_modulator;

    localparam int TAPS = 31;
    localparam int C    = 15;
    localparam int P    = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [11:0] audio_in = '0;
    logic               in_valid = 1'b0;
    logic               add_sub = 1'b0;
    logic signed [11:0] i_out, q_out;
    logic               out_valid, busy, overrun;
    logic [1:0]         dbg_state;

    always #5 clk = ~clk;

    ssb_modulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .audio_in (audio_in),
        .in_valid (in_valid),
        .add_sub  (add_sub),
        .i_out    (i_out),
        .q_out    (q_out),
        .out_valid(out_valid),
        .busy     (busy),
        .overrun  (overrun),
        .dbg_state(dbg_state)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [23:0] exp_q[$];
    int          acc_cyc_q[$];
    int          hb [8] = '{20861, 6120, 2828, 1343, 585, 215, 57, 5};
    int          xm [TAPS];
    int          ovr_exp = 0;
    int          ovr_seen = 0;
    logic [23:0] mon_e;
    int          mon_c;
    int          s, hi, hq;
    bit          hand;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference Q for the bench's own delay line copy.
    function automatic logic [11:0] model_q(input logic sb);
        longint acc = 0;
        longint qr, qv;
        for (int k = 0; k < P; k++) begin
            acc += longint'(hb[k]) * longint'(xm[C - (2*k+1)] - xm[C + (2*k+1)]);
        end
        qr = (acc + 16384) >>> 15;
        qv = sb ? qr : -qr;
`ifdef SSB_MOD_SATURATE_EN
        if (qv > 2047)  qv = 2047;
        if (qv < -2048) qv = -2048;
`endif
        return qv[11:0];
    endfunction

    // Issue one accepted sample; gap = edges until the next strobe may start.
    task automatic send(input int smp, input logic sb, input int gap,
                        input bit use_hand, input int h_i, input int h_q);
        logic [11:0] ei, eq;
        audio_in = 12'(smp);
        add_sub  = sb;
        in_valid = 1'b1;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = smp;
        ei = 12'(xm[C]);
        eq = model_q(sb);
        if (use_hand) begin
            ei = 12'(h_i);
            eq = 12'(h_q);
        end
        exp_q.push_back({ei, eq});
        @(posedge clk); #1;
        acc_cyc_q.push_back(cyc);
        check("busy_after_accept", busy, 1);
        check("no_overrun_on_accept", overrun, 0);
        in_valid = 1'b0;
        add_sub  = ~sb;
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    // Issue a strobe while busy: must be dropped and flagged.
    task automatic send_reject(input int smp, input logic sb);
        audio_in = 12'(smp);
        add_sub  = sb;
        in_valid = 1'b1;
        ovr_exp++;
        @(posedge clk); #1;
        check("overrun_pulse", overrun, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("overrun_one_cycle", overrun, 0);
    endtask

    // Monitor: compare each out_valid against the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overrun) ovr_seen++;
            if (out_valid) begin
                if (exp_q.size() == 0 || acc_cyc_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = acc_cyc_q.pop_front();
                    check("i_out", i_out, $signed(mon_e[23:12]));
                    check("q_out", q_out, $signed(mon_e[11:0]));
                    // High after edge E+9, i.e. captured downstream at edge E+10.
                    check("out_latency", cyc - mon_c, 9);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < TAPS; k++) xm[k] = 0;

        // Reset values while held in reset.
        repeat (3) @(posedge clk); #1;
        check("rst_i_out", i_out, 0);
        check("rst_q_out", q_out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // Idle: nothing moves.
        repeat (20) begin
            @(posedge clk); #1;
            check("idle_out_valid", out_valid, 0);
            check("idle_overrun", overrun, 0);
            check("idle_busy", busy, 0);
            check("idle_q_out", q_out, 0);
        end

        // Impulse, USB.
        for (int k = 1; k <= 32; k++) begin
            s    = (k == 1) ? 1024 : 0;
            hand = (k >= 15 && k <= 17);
            hi   = (k == 16) ? 1024 : 0;
            hq   = (k == 15) ? 652 : ((k == 17) ? -652 : 0);
            send(s, 1'b1, 16, hand, hi, hq);
        end

        // Impulse, LSB: Q sign inverted, I unchanged.
        for (int k = 1; k <= 32; k++) begin
            s    = (k == 1) ? 1024 : 0;
            hand = (k >= 15 && k <= 17);
            hi   = (k == 16) ? 1024 : 0;
            hq   = (k == 15) ? -652 : ((k == 17) ? 652 : 0);
            send(s, 1'b0, 16, hand, hi, hq);
        end

        // Overrun: second strobe 4 cycles after the first is dropped.
        send(300, 1'b1, 4, 1'b0, 0, 0);
        send_reject(-700, 1'b1);
        repeat (10) begin @(posedge clk); #1; end

        // DC 500; the 300 above passes through x[C] during this run.
        for (int k = 1; k <= 40; k++) send(500, 1'b1, 16, 1'b0, 0, 0);

        // Full-scale alternating, LSB.
        for (int k = 1; k <= 40; k++) begin
            s = (k % 2 == 0) ? 2047 : -2048;
            send(s, 1'b0, 16, 1'b0, 0, 0);
        end
        repeat (12) begin @(posedge clk); #1; end

        // Reset in the middle of a MAC run.
        audio_in = 12'sd777;
        add_sub  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("mid_mac_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_i_out", i_out, 0);
        check("abort_q_out", q_out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        for (int k = 0; k < TAPS; k++) xm[k] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            check("abort_no_out_valid", out_valid, 0);
        end

        // Delay line must be clear after the abort.
        for (int k = 1; k <= 17; k++) send(100 + k, 1'b1, 16, 1'b0, 0, 0);
        repeat (12) begin @(posedge clk); #1; end

        check("pending_outputs", exp_q.size(), 0);
        check("overrun_count", ovr_seen, ovr_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
